// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU writeback path
// (requester 0) and the load-return path (requester 1). A grant is decided
// combinationally each cycle, and the chosen payload is presented as a
// registered write command on the next cycle. Writes to $0 are accepted but
// never issued. Same-destination collisions are flagged, and cycles where both
// requesters compete are counted in a saturating counter.

module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,

  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,

  input  logic              prio_mode,
  input  logic              wb_stall,

  output logic              wb_sel,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_collide,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Requester identities; the encoding doubles as the mux select value.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  req_e              last_grant;
  logic              grant_alu;
  logic              grant_mem;
  logic              xfer;
  logic              both_valid;
  logic              same_dst;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  // Grant decision: stall or reset blocks everything, a lone requester wins,
  // ties go to mem under fixed priority, otherwise to whoever did not win last.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst_n && !wb_stall) begin
      if (alu_valid && mem_valid) begin
        if (prio_mode || (last_grant == REQ_ALU)) begin
          grant_mem = 1'b1;
        end else begin
          grant_alu = 1'b1;
        end
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // A grant is only ever given to a valid requester, so a grant is a transfer.
  assign xfer       = grant_alu | grant_mem;
  assign grant_addr = grant_mem ? mem_addr : alu_addr;
  assign grant_data = grant_mem ? mem_data : alu_data;

  // Contention and collision detection look at the raw requests, so they
  // still register while the write port is stalled.
  assign both_valid = alu_valid & mem_valid;
  assign same_dst   = (alu_addr == mem_addr) && (|alu_addr);

  // Round-robin history: remembers the winner of the most recent transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      last_grant <= REQ_MEM;
    end else if (xfer) begin
      last_grant <= grant_mem ? REQ_MEM : REQ_ALU;
    end
  end

  // Registered write command; payload holds between transfers, enable pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_sel  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= xfer && (|grant_addr);
      if (xfer) begin
        wb_sel  <= grant_mem;
        wb_addr <= grant_addr;
        wb_data <= grant_data;
      end
    end
  end

  // Collision flag: one-cycle pulse after both requesters target the same
  // nonzero register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_collide <= 1'b0;
    end else begin
      wb_collide <= both_valid && same_dst;
    end
  end

  // Contention counter: counts cycles with both requesters valid and sticks
  // at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (both_valid && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single requests, round-robin
// and fixed-priority ties, $0 drop, collision, stall, counter saturation and
// asynchronous reset in mid-operation.

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        prio_mode;
  logic        wb_stall;
  logic        wb_sel;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_collide;
  logic [7:0]  conflict_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(
    .ADDR_W(5),
    .DATA_W(16),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .prio_mode   (prio_mode),
    .wb_stall    (wb_stall),
    .wb_sel      (wb_sel),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_collide  (wb_collide),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rdy(input string tag, input logic a, input logic m);
    check({tag, "_alu_ready"}, 32'(alu_ready), 32'(a));
    check({tag, "_mem_ready"}, 32'(mem_ready), 32'(m));
  endtask

  task automatic check_wb(input string tag, input logic sel, input logic we,
                          input logic [4:0] addr, input logic [15:0] data);
    check({tag, "_sel"},  32'(wb_sel),  32'(sel));
    check({tag, "_we"},   32'(wb_we),   32'(we));
    check({tag, "_addr"}, 32'(wb_addr), 32'(addr));
    check({tag, "_data"}, 32'(wb_data), 32'(data));
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [15:0] md);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
  endtask

  // One clock edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    prio_mode = 1'b0;
    wb_stall  = 1'b0;
    drive(1'b1, 5'd3, 16'h0001, 1'b1, 5'd3, 16'h0002);

    // Reset held for two cycles with both requesters pushing.
    tick();
    tick();
    #1;
    check_rdy("rst", 1'b0, 1'b0);
    check_wb("rst", 1'b0, 1'b0, 5'd0, 16'h0000);
    check("rst_collide", 32'(wb_collide), 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);

    // Single ALU request after reset.
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'h0000);
    #1 check_rdy("t1", 1'b1, 1'b0);
    tick();
    check_wb("t1_wb", 1'b0, 1'b1, 5'd5, 16'h1234);
    drive(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
    #1 check_rdy("t1_idle", 1'b0, 1'b0);
    tick();
    check_wb("t1_hold", 1'b0, 1'b0, 5'd5, 16'h1234);

    // Single mem request: leaves last_grant on mem.
    drive(1'b0, 5'd0, 16'h0000, 1'b1, 5'd2, 16'h0202);
    #1 check_rdy("m1", 1'b0, 1'b1);
    tick();
    check_wb("m1_wb", 1'b1, 1'b1, 5'd2, 16'h0202);

    // Round-robin tie for four cycles: ALU, mem, ALU, mem.
    drive(1'b1, 5'd3, 16'h00A3, 1'b1, 5'd7, 16'h00B7);
    for (int i = 0; i < 4; i++) begin
      #1 check_rdy("rr", (i % 2) == 0, (i % 2) == 1);
      tick();
      check_wb("rr_wb", (i % 2) == 1, 1'b1,
               ((i % 2) == 1) ? 5'd7 : 5'd3,
               ((i % 2) == 1) ? 16'h00B7 : 16'h00A3);
    end
    check("rr_cnt", 32'(conflict_cnt), 32'd4);
    check("rr_collide", 32'(wb_collide), 32'd0);

    // Fixed priority: mem wins every tie, then ALU alone is granted.
    prio_mode = 1'b1;
    drive(1'b1, 5'd4, 16'h0044, 1'b1, 5'd6, 16'h0066);
    for (int i = 0; i < 3; i++) begin
      #1 check_rdy("fp", 1'b0, 1'b1);
      tick();
      check_wb("fp_wb", 1'b1, 1'b1, 5'd6, 16'h0066);
    end
    check("fp_cnt", 32'(conflict_cnt), 32'd7);
    drive(1'b1, 5'd4, 16'h0044, 1'b0, 5'd0, 16'h0000);
    #1 check_rdy("fp_alu", 1'b1, 1'b0);
    tick();
    check_wb("fp_alu_wb", 1'b0, 1'b1, 5'd4, 16'h0044);
    prio_mode = 1'b0;

    // Write to $0: accepted, payload captured, no write enable.
    drive(1'b1, 5'd0, 16'hDEAD, 1'b0, 5'd0, 16'h0000);
    #1 check_rdy("z0", 1'b1, 1'b0);
    tick();
    check_wb("z0_wb", 1'b0, 1'b0, 5'd0, 16'hDEAD);

    // Collision on $9: last_grant is ALU, so mem goes first, then ALU.
    drive(1'b1, 5'd9, 16'h0909, 1'b1, 5'd9, 16'h9999);
    #1 check_rdy("col", 1'b0, 1'b1);
    tick();
    check_wb("col_wb1", 1'b1, 1'b1, 5'd9, 16'h9999);
    check("col_pulse", 32'(wb_collide), 32'd1);
    check("col_cnt", 32'(conflict_cnt), 32'd8);
    drive(1'b1, 5'd9, 16'h0909, 1'b0, 5'd0, 16'h0000);
    #1 check_rdy("col2", 1'b1, 1'b0);
    tick();
    check_wb("col_wb2", 1'b0, 1'b1, 5'd9, 16'h0909);
    check("col_pulse_end", 32'(wb_collide), 32'd0);
    check("col_cnt2", 32'(conflict_cnt), 32'd8);
    drive(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 16'h0000);
    tick();
    check_wb("col_idle", 1'b0, 1'b0, 5'd9, 16'h0909);

    // Stall for three cycles with both valid: nothing granted, count moves.
    wb_stall = 1'b1;
    drive(1'b1, 5'd1, 16'h0011, 1'b1, 5'd2, 16'h0022);
    for (int i = 0; i < 3; i++) begin
      #1 check_rdy("stall", 1'b0, 1'b0);
      tick();
      check_wb("stall_wb", 1'b0, 1'b0, 5'd9, 16'h0909);
    end
    check("stall_cnt", 32'(conflict_cnt), 32'd11);
    wb_stall = 1'b0;
    #1 check_rdy("unstall", 1'b0, 1'b1);
    tick();
    check_wb("unstall_wb", 1'b1, 1'b1, 5'd2, 16'h0022);
    check("unstall_cnt", 32'(conflict_cnt), 32'd12);

    // Stall raised while a write is on the outputs leaves that write intact.
    wb_stall = 1'b1;
    #1 check_rdy("late_stall", 1'b0, 1'b0);
    check("late_stall_we", 32'(wb_we), 32'd1);
    wb_stall = 1'b0;

    // Saturation: 300 tied cycles on top of 12 already counted.
    for (int i = 0; i < 242; i++) tick();
    check("sat_254", 32'(conflict_cnt), 32'd254);
    tick();
    check("sat_255", 32'(conflict_cnt), 32'd255);
    for (int i = 0; i < 57; i++) tick();
    check("sat_hold", 32'(conflict_cnt), 32'd255);
    check("sat_we", 32'(wb_we), 32'd1);

    // Asynchronous reset between edges clears everything immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_rdy("arst", 1'b0, 1'b0);
    check_wb("arst", 1'b0, 1'b0, 5'd0, 16'h0000);
    check("arst_cnt", 32'(conflict_cnt), 32'd0);
    check("arst_collide", 32'(wb_collide), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 check_rdy("post_rst", 1'b1, 1'b0);
    tick();
    check_wb("post_rst_wb", 1'b0, 1'b1, 5'd1, 16'h0011);
    check("post_rst_cnt", 32'(conflict_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the single register-file write port of the MIPS 16-bit processor between two writeback sources: the ALU result path (requester 0) and the load/memory return path (requester 1). It drives the select of the 5-bit destination-address 2:1 mux (`wb_sel`) and presents a registered write command (enable, address, data) to the register file. It issues one write per cycle, uses round-robin or fixed-priority policy, drops writes to $0, and keeps a saturating conflict counter for performance visibility.

## Interface
- `ADDR_W`, 5: register address width.
- `DATA_W`, 16: register data width.
- `CNT_W`, 8: conflict counter width.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_addr`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load writeback request.
- `mem_addr`  in  ADDR_W  load destination register.
- `mem_data`  in  DATA_W  load data.
- `mem_ready`  out  1  load request accepted this cycle.
- `prio_mode`  in  1  0 = round-robin, 1 = mem fixed priority.
- `wb_stall`  in  1  register file cannot accept a write this cycle.
- `wb_sel`  out  1  address/data mux select: 0 = ALU, 1 = mem.
- `wb_we`  out  1  register-file write enable.
- `wb_addr`  out  ADDR_W  write address.
- `wb_data`  out  DATA_W  write data.
- `wb_collide`  out  1  pulse: both requests in the same cycle targeted the same nonzero register.
- `conflict_cnt`  out  CNT_W  saturating count of cycles with both requesters valid.

## Operation
- Handshake: a requester holds `valid` and its payload stable until it sees `ready` high on a rising edge. Transfer happens when `valid && ready`. `ready` is combinational from the current valid inputs, `wb_stall`, `prio_mode`, and the `last_grant` register.
- When `wb_stall`=1, both `ready` signals are 0. No transfer occurs and no state changes, except `conflict_cnt`, which still counts.
- When `wb_stall`=0, the grant is:
  - Only one requester valid: grant it.
  - Both valid, `prio_mode`=1: grant mem.
  - Both valid, `prio_mode`=0: grant the requester that is not `last_grant`.
- Every grant updates `last_grant` to the granted requester, in either mode.
- `last_grant` resets to 1 (mem), so the first tie after reset goes to the ALU.
- At most one `ready` is high per cycle.
- Write command on transfer: the next cycle, `wb_sel` is the granted index and `wb_addr`/`wb_data` hold the granted payload. `wb_we` is 1 only if the address is nonzero. A write to $0 is accepted, `ready` goes high, and no write is issued.
- `wb_sel`, `wb_addr` and `wb_data` hold their last values when no transfer occurs. `wb_we` is 0 in every cycle not directly following a transfer.
- Collision: `wb_collide` is registered. It is 1 in the cycle after any cycle where both requesters are valid with equal, nonzero addresses, regardless of stall. There is no reordering: the register file keeps whichever write issues last.
- `conflict_cnt` increments by 1 each cycle both requesters are valid. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Request to write latency: 1 cycle. A transfer at edge N gives `wb_we`/`wb_addr`/`wb_data`/`wb_sel` valid from N until N+1.
- Throughput: one write per cycle. Under a continuous tie in round-robin mode, grants alternate ALU, mem, ALU, and so on.
- Reset values (asynchronous, applied immediately on `rst_n` low): `wb_we`=0, `wb_sel`=0, `wb_addr`=0, `wb_data`=0, `wb_collide`=0, `conflict_cnt`=0, `last_grant`=1. While `rst_n` is low, `alu_ready`=`mem_ready`=0.
- Reset in mid-operation: any in-flight write command is cancelled (`wb_we` forced to 0). Requesters must re-present after reset.
- Switching `prio_mode` takes effect in the same cycle; `last_grant` is not reset.
- `wb_stall` rising while a write is on the outputs does not cancel that write. It blocks only new grants.

## Test plan
- Reset then a single request: `rst_n` low for 2 cycles, then `alu_valid`=1 with addr=5, data=0x1234 → `alu_ready`=1 in that cycle; next cycle `wb_we`=1, `wb_sel`=0, `wb_addr`=5, `wb_data`=0x1234; then `wb_we`=0.
- Round-robin tie: both valid for 4 cycles (ALU addr 3, mem addr 7) → grant order ALU, mem, ALU, mem; `wb_sel` = 0,1,0,1 one cycle later; `conflict_cnt`=4.
- Fixed priority: `prio_mode`=1, both valid for 3 cycles → `mem_ready`=1 and `alu_ready`=0 each cycle. Then drop `mem_valid` → ALU granted the next cycle.
- $0 drop and collision: ALU addr 0 → accepted, `wb_we` stays 0. Then both valid with addr 9 → `wb_collide`=1 for exactly 1 cycle; both writes issue on consecutive cycles in round-robin order.
- Stall: hold `wb_stall`=1 for 3 cycles with both valid → no `ready`, `wb_we`=0, `conflict_cnt` +3. Release → normal grants resume with `last_grant` unchanged.
- Saturation and asynchronous reset: `CNT_W`=8, 300 tied cycles → `conflict_cnt`=255. Assert `rst_n` low mid-cycle → all outputs go to 0 immediately; the first tie after release is granted to the ALU.
